// File: rtl/window_filter_3x3.sv
// window_filter_3x3
// Pipelined 3x3 neighbourhood filter fed by the line-buffer controller.
// Each valid beat carries a 3x3 window and a filter mode. The beat walks
// through three stages (capture, partial sums, final result) and leaves
// through registered outputs, so the result appears three edges after capture.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low
//   inData[71:0]   window, pixel i = inData[8i+7:8i], row 0 = oldest line, p4 = centre
//   inDataValid    window valid this cycle (no backpressure)
//   mode[1:0]      00 box, 01 Gaussian, 10 Sobel, 11 pass-through
//   outData[7:0]   filtered pixel
//   outDataValid   outData valid this cycle
//   outLineEnd     marks the last output pixel of a line
//   outPixelIndex  column index of the current output beat
module window_filter_3x3 #(
  parameter int unsigned LINE_WIDTH = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [71:0] inData,
  input  logic        inDataValid,
  input  logic [1:0]  mode,
  output logic [7:0]  outData,
  output logic        outDataValid,
  output logic        outLineEnd,
  output logic [15:0] outPixelIndex
);

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned NUM_PIX = 9;
  localparam int unsigned WIN_W   = PIX_W * NUM_PIX;
  localparam int unsigned SUM_W   = 12;
  localparam int unsigned EDGE_W  = 10;
  localparam int unsigned GRAD_W  = 11;
  localparam int unsigned PROD_W  = 24;
  localparam int unsigned IDX_W   = 16;
  // 7282 / 65536 approximates 1/9 closely enough to be exact for S <= 2295
  localparam int unsigned BOX_RECIP = 7282;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_BOX   = 2'b00,
    MODE_GAUSS = 2'b01,
    MODE_SOBEL = 2'b10,
    MODE_PASS  = 2'b11
  } filterMode_t;

  // Stage 1: captured window
  logic             s1Valid;
  logic [WIN_W-1:0] s1Data;
  filterMode_t      s1Mode;

  // Stage 2: partial results for every mode
  logic                     s2Valid;
  filterMode_t              s2Mode;
  logic [SUM_W-1:0]         s2Box;
  logic [SUM_W-1:0]         s2Gauss;
  logic signed [GRAD_W-1:0] s2Gx;
  logic signed [GRAD_W-1:0] s2Gy;
  logic [PIX_W-1:0]         s2Centre;

  // Stage 3: final 8-bit result
  logic             s3Valid;
  logic [PIX_W-1:0] s3Data;

  logic [IDX_W-1:0] pixelCount;

  // Window capture; data holds during gaps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1Valid <= 1'b0;
      s1Data  <= '0;
      s1Mode  <= MODE_BOX;
    end else begin
      s1Valid <= inDataValid;
      if (inDataValid) begin
        s1Data <= inData;
        s1Mode <= filterMode_t'(mode);
      end
    end
  end

  // Partial sums from the captured window
  logic [PIX_W-1:0]         pix [NUM_PIX];
  logic [SUM_W-1:0]         boxSum;
  logic [SUM_W-1:0]         gaussSum;
  logic [EDGE_W-1:0]        rightCol;
  logic [EDGE_W-1:0]        leftCol;
  logic [EDGE_W-1:0]        bottomRow;
  logic [EDGE_W-1:0]        topRow;
  logic signed [GRAD_W-1:0] gradX;
  logic signed [GRAD_W-1:0] gradY;

  always_comb begin
    for (int i = 0; i < int'(NUM_PIX); i++) begin
      pix[i] = s1Data[PIX_W*i +: PIX_W];
    end
    boxSum = '0;
    for (int i = 0; i < int'(NUM_PIX); i++) begin
      boxSum = boxSum + SUM_W'(pix[i]);
    end
    // Corners x1, edges x2, centre x4
    gaussSum = SUM_W'(pix[0]) + SUM_W'(pix[2]) + SUM_W'(pix[6]) + SUM_W'(pix[8])
             + ((SUM_W'(pix[1]) + SUM_W'(pix[3]) + SUM_W'(pix[5]) + SUM_W'(pix[7])) << 1)
             + (SUM_W'(pix[4]) << 2);
    rightCol  = EDGE_W'(pix[2]) + (EDGE_W'(pix[5]) << 1) + EDGE_W'(pix[8]);
    leftCol   = EDGE_W'(pix[0]) + (EDGE_W'(pix[3]) << 1) + EDGE_W'(pix[6]);
    bottomRow = EDGE_W'(pix[6]) + (EDGE_W'(pix[7]) << 1) + EDGE_W'(pix[8]);
    topRow    = EDGE_W'(pix[0]) + (EDGE_W'(pix[1]) << 1) + EDGE_W'(pix[2]);
    // Operands are at most 1020, so the 11-bit difference never wraps
    gradX = $signed(GRAD_W'(rightCol) - GRAD_W'(leftCol));
    gradY = $signed(GRAD_W'(bottomRow) - GRAD_W'(topRow));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2Valid  <= 1'b0;
      s2Mode   <= MODE_BOX;
      s2Box    <= '0;
      s2Gauss  <= '0;
      s2Gx     <= '0;
      s2Gy     <= '0;
      s2Centre <= '0;
    end else begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Mode   <= s1Mode;
        s2Box    <= boxSum;
        s2Gauss  <= gaussSum;
        s2Gx     <= gradX;
        s2Gy     <= gradY;
        s2Centre <= pix[4];
      end
    end
  end

  // Final result selected by the beat's own mode
  logic [EDGE_W-1:0] absGx;
  logic [EDGE_W-1:0] absGy;
  logic [GRAD_W-1:0] sobelMag;
  logic [PIX_W-1:0]  boxOut;
  logic [PIX_W-1:0]  gaussOut;
  logic [PIX_W-1:0]  sobelOut;
  logic [PIX_W-1:0]  resultC;

  always_comb begin
    boxOut   = PIX_W'((PROD_W'(s2Box) * PROD_W'(BOX_RECIP)) >> 16);
    gaussOut = PIX_W'(s2Gauss >> 4);
    absGx    = s2Gx[GRAD_W-1] ? EDGE_W'(-s2Gx) : EDGE_W'(s2Gx);
    absGy    = s2Gy[GRAD_W-1] ? EDGE_W'(-s2Gy) : EDGE_W'(s2Gy);
    sobelMag = GRAD_W'(absGx) + GRAD_W'(absGy);
    sobelOut = (sobelMag > GRAD_W'(255)) ? 8'hFF : PIX_W'(sobelMag);
    resultC  = s2Centre;
    case (s2Mode)
      MODE_BOX:   resultC = boxOut;
      MODE_GAUSS: resultC = gaussOut;
      MODE_SOBEL: resultC = sobelOut;
      MODE_PASS:  resultC = s2Centre;
      default:    resultC = s2Centre;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s3Valid <= 1'b0;
      s3Data  <= '0;
    end else begin
      s3Valid <= s2Valid;
      if (s2Valid) begin
        s3Data <= resultC;
      end
    end
  end

  // Output register and line position counter; both hold during gaps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outData       <= '0;
      outDataValid  <= 1'b0;
      outLineEnd    <= 1'b0;
      outPixelIndex <= '0;
      pixelCount    <= '0;
    end else begin
      outDataValid <= s3Valid;
      outLineEnd   <= 1'b0;
      if (s3Valid) begin
        outData       <= s3Data;
        outPixelIndex <= pixelCount;
        outLineEnd    <= (pixelCount == LAST_IDX);
        pixelCount    <= (pixelCount == LAST_IDX) ? '0 : pixelCount + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_window_filter_3x3.sv
module tb_window_filter_3x3;

  localparam int LW = 512;

  logic        clk;
  logic        reset;
  logic [71:0] inData;
  logic        inDataValid;
  logic [1:0]  mode;
  logic [7:0]  outData;
  logic        outDataValid;
  logic        outLineEnd;
  logic [15:0] outPixelIndex;

  window_filter_3x3 #(.LINE_WIDTH(LW)) dut (
    .clk           (clk),
    .reset         (reset),
    .inData        (inData),
    .inDataValid   (inDataValid),
    .mode          (mode),
    .outData       (outData),
    .outDataValid  (outDataValid),
    .outLineEnd    (outLineEnd),
    .outPixelIndex (outPixelIndex)
  );

  typedef struct {
    int data;
    int edgeNo;
  } expBeat_t;

  expBeat_t sbQ[$];
  int nCompared = 0;
  int nFail     = 0;
  int cycleCount = 0;
  int modelIdx  = 0;
  int outCount  = 0;
  int leCount   = 0;
  int validSeen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount++;

  task automatic check(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [71:0] win(input int a0, input int a1, input int a2,
                                      input int a3, input int a4, input int a5,
                                      input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Reference filter written directly from the filter definitions
  function automatic int refModel(input logic [71:0] w, input logic [1:0] m);
    int p[9];
    int s, gx, gy, mag;
    for (int i = 0; i < 9; i++) p[i] = int'(w[8*i +: 8]);
    case (m)
      2'b00: begin
        s = 0;
        for (int i = 0; i < 9; i++) s += p[i];
        return (s * 7282) >>> 16;
      end
      2'b01: begin
        s = p[0] + 2*p[1] + p[2] + 2*p[3] + 4*p[4] + 2*p[5] + p[6] + 2*p[7] + p[8];
        return s / 16;
      end
      2'b10: begin
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag > 255) ? 255 : mag;
      end
      default: return p[4];
    endcase
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    expBeat_t e;
    if (outDataValid) begin
      validSeen++;
      if (sbQ.size() == 0) begin
        nCompared++;
        nFail++;
        $display("FAIL unexpected_output: got data %0d index %0d, expected no beat", outData, outPixelIndex);
      end else begin
        e = sbQ.pop_front();
        check("data", int'(outData), e.data);
        check("latency", cycleCount, e.edgeNo + 3);
        check("index", int'(outPixelIndex), modelIdx);
        check("lineEnd", int'(outLineEnd), int'(modelIdx == LW - 1));
        if (outLineEnd) leCount++;
        outCount++;
        modelIdx = (modelIdx == LW - 1) ? 0 : modelIdx + 1;
      end
    end else if (outLineEnd) begin
      check("lineEnd_idle", int'(outLineEnd), 0);
    end
  end

  task automatic sendBeatNow(input logic [71:0] d, input logic [1:0] m, input int expected);
    expBeat_t e;
    inData      = d;
    mode        = m;
    inDataValid = 1'b1;
    e.data      = expected;
    e.edgeNo    = cycleCount + 1;
    sbQ.push_back(e);
  endtask

  task automatic sendBeat(input logic [71:0] d, input logic [1:0] m, input int expected);
    @(negedge clk);
    sendBeatNow(d, m, expected);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      inDataValid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int waited = 0;
    @(negedge clk);
    inDataValid = 1'b0;
    while (sbQ.size() != 0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check(name, sbQ.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic resetPulse();
    @(negedge clk);
    reset = 1'b0;
    inDataValid = 1'b0;
    sbQ.delete();
    modelIdx = 0;
    outCount = 0;
    leCount  = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [71:0] w;
    logic [1:0]  m;
    int vBefore;
    reset = 1'b1;
    inData = '0;
    inDataValid = 1'b0;
    mode = 2'b00;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_outData", int'(outData), 0);
    check("rst_outDataValid", int'(outDataValid), 0);
    check("rst_outLineEnd", int'(outLineEnd), 0);
    check("rst_outPixelIndex", int'(outPixelIndex), 0);
    repeat (2) @(negedge clk);

    // Beat presented together with reset release, then uniform 0x80 in every mode
    @(negedge clk);
    reset = 1'b1;
    sendBeatNow(win(128,128,128,128,128,128,128,128,128), 2'b00, 128);
    sendBeat(win(128,128,128,128,128,128,128,128,128), 2'b01, 128);
    sendBeat(win(128,128,128,128,128,128,128,128,128), 2'b10, 0);
    sendBeat(win(128,128,128,128,128,128,128,128,128), 2'b11, 128);
    idle(2);
    sendBeat(win(255,255,255,255,255,255,255,255,255), 2'b00, 255);
    sendBeat(win(0,0,0,0,9,0,0,0,0), 2'b00, 1);
    idle(1);
    sendBeat(win(0,0,0,0,160,0,0,0,0), 2'b01, 40);
    sendBeat(win(0,0,10,0,0,10,0,0,10), 2'b10, 40);
    sendBeat(win(0,0,255,0,0,255,0,0,255), 2'b10, 255);
    sendBeat(win(255,0,0,255,0,0,255,0,0), 2'b10, 255);
    sendBeat(win(0,0,0,0,0,0,0,20,0), 2'b10, 40);
    sendBeat(win(0,20,0,0,0,0,0,0,0), 2'b10, 40);
    sendBeat(win(1,2,3,4,90,6,7,8,9), 2'b11, 90);
    drain("drain_directed");

    // Mode cycling on back-to-back random windows
    for (int i = 0; i < 40; i++) begin
      w = {$urandom, $urandom, $urandom};
      m = 2'(i % 4);
      sendBeat(w, m, refModel(w, m));
    end
    drain("drain_modecycle");

    // Streaming with random gaps from a fresh line position
    resetPulse();
    for (int i = 0; i < 1100; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      w = {$urandom, $urandom, $urandom};
      m = 2'($urandom_range(0, 3));
      sendBeat(w, m, refModel(w, m));
    end
    drain("drain_stream");
    check("stream_outputs", outCount, 1100);
    check("stream_lineEnds", leCount, 2);
    check("stream_final_index", int'(outPixelIndex), 75);

    // Asynchronous reset with three beats in flight
    sendBeat(win(200,200,200,200,200,200,200,200,200), 2'b11, 200);
    sendBeat(win(100,100,100,100,100,100,100,100,100), 2'b11, 100);
    sendBeat(win(50,50,50,50,50,50,50,50,50), 2'b11, 50);
    @(posedge clk);
    #3;
    inDataValid = 1'b0;
    reset = 1'b0;
    sbQ.delete();
    modelIdx = 0;
    #1;
    check("async_outData", int'(outData), 0);
    check("async_outDataValid", int'(outDataValid), 0);
    check("async_outLineEnd", int'(outLineEnd), 0);
    check("async_outPixelIndex", int'(outPixelIndex), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    vBefore = validSeen;
    repeat (8) @(negedge clk);
    check("no_inflight_after_reset", validSeen - vBefore, 0);
    sendBeat(win(51,51,51,51,51,51,51,51,51), 2'b11, 51);
    drain("drain_post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule
